sramlike_sram_responder: RTL and testbench
==========================================

SRAMLIKE_SRAM_RESPONDER -- requirements
Module: sramlike_sram_responder

Interface
REQ-001 SHALL use one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter LATENCY, 1, cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 Port clk  in  1  clock.
REQ-004 Port rst  in  1  synchronous active-high reset.
REQ-005 Ports req/wr/size/addr/wdata  in  1/1/2/32/32  sram-like request from initiator; wr=1 is a write.
REQ-006 Ports addr_ok/data_ok  out  1/1  address and data handshake to initiator.
REQ-007 Port rdata  out  32  read data to initiator.
REQ-008 Ports ram_en/ram_wen/ram_addr/ram_wdata  out  1/4/32/32  synchronous SRAM request.
REQ-009 Port ram_rdata  in  32  SRAM read data, valid exactly one cycle after ram_en.

Function
REQ-010 SHALL implement FSM {IDLE, WAIT, RESP}; at most one transaction outstanding.
REQ-011 In IDLE and RESP, addr_ok SHALL be 1; in WAIT, addr_ok SHALL be 0.
REQ-012 A transaction SHALL be accepted in a cycle where req & addr_ok.
REQ-013 In the accept cycle, ram_en=1, ram_addr=addr, ram_wdata=wdata; ram_wen=0 for reads.
REQ-014 ram_wen for writes: size 00 -> 4'b0001<<addr[1:0]; size 01 -> addr[1] ? 4'b1100 : 4'b0011; size 10 -> 4'b1111.
REQ-015 Misaligned writes (size 01 with addr[0]=1, size 10 with addr[1:0]!=0) and size 11 SHALL be accepted with ram_wen=0 and completed normally.
REQ-016 data_ok SHALL pulse for exactly one cycle, LATENCY cycles after the accept cycle; the FSM is in RESP during that cycle.
REQ-017 Transitions: IDLE->RESP on accept when LATENCY=1; IDLE->WAIT on accept when LATENCY>1; WAIT->RESP when the 4-bit counter reaches LATENCY-1; RESP->RESP on a new accept when LATENCY=1; RESP->WAIT on a new accept when LATENCY>1; RESP->IDLE otherwise.
REQ-018 A request accepted in a RESP cycle (addr_ok and data_ok in the same cycle) SHALL be served back-to-back without a bubble.
REQ-019 rdata SHALL equal ram_rdata in the cycle after an accept; ram_rdata SHALL be captured into a hold register in that cycle.
REQ-020 In all other cycles rdata SHALL come from the hold register; it stays stable until the next read is captured.
REQ-021 For writes, rdata SHALL be unchanged and data_ok timing SHALL be identical to reads.
REQ-022 req deasserting while in WAIT SHALL NOT cancel the transaction; every accepted transaction SHALL complete with exactly one data_ok.
REQ-023 ram_en SHALL be 0 in every cycle that is not an accept cycle.

Reset
REQ-024 While rst=1: state=IDLE, counter=0, hold register=0, addr_ok=0, data_ok=0, ram_en=0, ram_wen=0, rdata=0.
REQ-025 rst asserted mid-transaction SHALL abandon the transaction; no data_ok SHALL follow reset release.
REQ-026 addr_ok SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-027 Macro RESP_RANDOM_DELAY_EN SHALL select whether random back-pressure is compiled in.
REQ-028 With the macro: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) SHALL advance every cycle.
REQ-029 With the macro: addr_ok in IDLE/RESP SHALL be additionally gated by lfsr[0].
REQ-030 With the macro: each transaction SHALL get lfsr[2:1] extra WAIT cycles, latched at accept.
REQ-031 Without the macro: no LFSR SHALL exist, and timing SHALL be exactly as in REQ-011 to REQ-018.

Structure
REQ-032 Shared package sramlike_pkg SHALL hold SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, the FSM state encoding, and the LFSR seed.
REQ-033 Byte-enable decode (REQ-014/015) SHALL be the sub-module sramlike_wen_gen (size, addr[1:0], wr -> wen[3:0]).

Verification
REQ-034 LATENCY=1, read addr 0x1FC00000 where ram holds 0x3C1A0000 -> data_ok at accept+1, rdata=0x3C1A0000, addr_ok remains 1.
REQ-035 LATENCY=3, req held high for back-to-back reads 0x0, 0x4 -> data_ok at accept+3; second accept happens in the RESP cycle of the first; addr_ok=0 in both WAIT cycles.
REQ-036 Byte write size 00, addr 0x103, wdata 0xAB000000 -> ram_wen=4'b1000; halfword write addr 0x102 -> 4'b1100; word write addr 0x101 -> ram_wen=4'b0000, data_ok still issued.
REQ-037 LATENCY=4, rst pulsed for 1 cycle at accept+2 -> data_ok never asserted; addr_ok=1 in the cycle after rst falls.
REQ-038 LATENCY=2, read then write back-to-back -> rdata keeps the read value through the write's data_ok.
REQ-039 RESP_RANDOM_DELAY_EN defined, 1000 random reads -> data_ok count equals accept count, and every rdata matches the memory model.

Source files
------------

// File: rtl/sramlike_pkg.sv
// Shared definitions for the sram-like responder: transfer sizes, FSM encoding, LFSR seed.
// No logic of its own; the LFSR step helper is only used when back-pressure is compiled in.
package sramlike_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/sramlike_wen_gen.sv
// Byte-lane write-enable decode from size and address low bits; purely combinational.
// Reads, misaligned writes and size 11 produce no lanes, so the access still completes harmlessly.
module sramlike_wen_gen
    import sramlike_pkg::*;
(
    input  logic       wr,
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wen
);

    always_comb begin
        wen = 4'b0000;
        if (wr) begin
            case (size)
                SIZE_BYTE: wen = 4'b0001 << addr_lo;
                SIZE_HALF: if (!addr_lo[0]) wen = addr_lo[1] ? 4'b1100 : 4'b0011;
                SIZE_WORD: if (addr_lo == 2'b00) wen = 4'b1111;
                default:   wen = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/sramlike_sram_responder.sv
// Sram-like slave in front of a 1-cycle synchronous SRAM; data_ok LATENCY cycles after accept, one transaction in flight.
// addr_ok drops while waiting; `RESP_RANDOM_DELAY_EN adds LFSR-driven addr_ok gating and extra wait cycles.
module sramlike_sram_responder
    import sramlike_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

`ifdef RESP_RANDOM_DELAY_EN
    // up to 3 extra wait cycles on top of LATENCY-1 need a fifth bit
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LATENCY - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   wait_target;
    logic               accept;
    logic               direct_resp;
    logic               issue_gate;
    logic               rd_pend;
    logic [31:0]        hold;
    logic [3:0]         wen_dec;

`ifdef RESP_RANDOM_DELAY_EN
    logic [7:0] lfsr;
    logic [1:0] extra;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= LFSR_SEED;
            extra <= 2'b00;
        end else begin
            lfsr <= lfsr_next(lfsr);
            if (accept) extra <= lfsr[2:1];
        end
    end

    assign issue_gate  = lfsr[0];
    assign wait_target = LAST_WAIT + CNT_W'(extra);
    assign direct_resp = (LATENCY == 1) && (lfsr[2:1] == 2'b00);
`else
    assign issue_gate  = 1'b1;
    assign wait_target = LAST_WAIT;
    assign direct_resp = (LATENCY == 1);
`endif

    assign accept = req & addr_ok;

    sramlike_wen_gen u_wen_gen (
        .wr      (wr),
        .size    (size),
        .addr_lo (addr[1:0]),
        .wen     (wen_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = direct_resp ? RESP : WAIT;
            WAIT: if (cnt == wait_target) state_nxt = RESP;
            RESP: begin
                if (accept) state_nxt = direct_resp ? RESP : WAIT;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs are forced quiet during reset regardless of the state register
    always_comb begin
        addr_ok   = ~rst & issue_gate & (state != WAIT);
        data_ok   = ~rst & (state == RESP);
        ram_en    = accept;
        ram_wen   = accept ? wen_dec : 4'b0000;
        ram_addr  = addr;
        ram_wdata = wdata;
        rdata     = rst ? 32'h0 : (rd_pend ? ram_rdata : hold);
    end

    // counter holds the number of wait cycles already spent, starting at 1 in the first WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(1);
        end else if (state == WAIT && cnt != wait_target) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            hold    <= 32'h0;
        end else begin
            rd_pend <= accept & ~wr;
            if (rd_pend) hold <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_sramlike_sram_responder.sv
// Four responders with LATENCY 1..4 driven by directed vectors against a fixed read-only memory pattern.
module tb_sramlike_sram_responder;
    import sramlike_pkg::*;

    logic        clk;
    logic        rst       [4];
    logic        req       [4];
    logic        wr        [4];
    logic [1:0]  size      [4];
    logic [31:0] addr      [4];
    logic [31:0] wdata     [4];
    logic        addr_ok   [4];
    logic        data_ok   [4];
    logic [31:0] rdata     [4];
    logic        ram_en    [4];
    logic [3:0]  ram_wen   [4];
    logic [31:0] ram_addr  [4];
    logic [31:0] ram_wdata [4];
    logic [31:0] ram_rdata [4];

    int n_tests = 0;
    int n_fail  = 0;
    int n_dok   = 0;
    int n_acc   = 0;
    int issued  = 0;
    logic acc_last;
    logic [31:0] expq [$];
    logic [31:0] exp_word;

    logic [1:0]  wsz  [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [31:0] wad  [8] = '{32'h103, 32'h102, 32'h101, 32'h101, 32'h100, 32'h101, 32'h100, 32'h100};
    logic [3:0]  wexp [8] = '{4'b1000, 4'b1100, 4'b0000, 4'b0010, 4'b0011, 4'b0000, 4'b1111, 4'b0000};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sramlike_sram_responder #(.LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req       (req[g]),
            .wr        (wr[g]),
            .size      (size[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .addr_ok   (addr_ok[g]),
            .data_ok   (data_ok[g]),
            .rdata     (rdata[g]),
            .ram_en    (ram_en[g]),
            .ram_wen   (ram_wen[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
        );
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h1FC0_0000) ? 32'h3C1A_0000 : {a[15:0], ~a[15:0]};
    endfunction

    // SRAM model: data for any enabled access appears one cycle later
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_en[i]) ram_rdata[i] <= mem_fn(ram_addr[i]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req[i]   = r;
        wr[i]    = w;
        size[i]  = s;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            drive(i, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        end
        drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h1FC0_0000, 32'h0);

        // reset state with a request pending
        @(negedge clk); #1;
        check("rst_addr_ok", addr_ok[0], 1'b0);
        check("rst_data_ok", data_ok[0], 1'b0);
        check("rst_ram_en",  ram_en[0],  1'b0);
        check("rst_ram_wen", ram_wen[0], 4'b0000);
        check("rst_rdata",   rdata[0],   32'h0);

        @(negedge clk);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        drive(0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("post_rst_addr_ok0", addr_ok[0], 1'b1);
        check("post_rst_addr_ok3", addr_ok[3], 1'b1);

`ifdef RESP_RANDOM_DELAY_EN
        acc_last = 1'b0;
        for (int c = 0; c < 20000 && (issued < 1000 || expq.size() != 0); c++) begin
            @(negedge clk);
            if (acc_last) drive(0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
            acc_last = 1'b0;
            if (!req[0] && issued < 1000)
                drive(0, 1'b1, 1'b0, SIZE_WORD, {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 32'h0);
            #1;
            if (data_ok[0]) begin
                n_dok++;
                if (expq.size() == 0) begin
                    check("rnd_spurious_dok", 32'd1, 32'd0);
                end else begin
                    exp_word = expq.pop_front();
                    check("rnd_rdata", rdata[0], exp_word);
                end
            end
            if (req[0] && addr_ok[0]) begin
                n_acc++;
                issued++;
                acc_last = 1'b1;
                expq.push_back(mem_fn(addr[0]));
            end
        end
        check("rnd_acc_cnt", n_acc, 32'd1000);
        check("rnd_dok_cnt", n_dok, n_acc);
`else
        // LATENCY=1 read of the boot vector
        @(negedge clk);
        drive(0, 1'b1, 1'b0, SIZE_WORD, 32'h1FC0_0000, 32'h0);
        #1;
        check("l1_ram_en",   ram_en[0],   1'b1);
        check("l1_ram_addr", ram_addr[0], 32'h1FC0_0000);
        check("l1_ram_wen",  ram_wen[0],  4'b0000);
        check("l1_dok_early", data_ok[0], 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("l1_data_ok", data_ok[0], 1'b1);
        check("l1_rdata",   rdata[0],   32'h3C1A_0000);
        check("l1_addr_ok", addr_ok[0], 1'b1);
        check("l1_idle_en", ram_en[0],  1'b0);
        @(negedge clk); #1;
        check("l1_dok_once", data_ok[0], 1'b0);
        check("l1_hold",     rdata[0],   32'h3C1A_0000);

        // LATENCY=1 back-to-back writes through the byte-enable table
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(0, 1'b1, 1'b1, wsz[k], wad[k], 32'hAB00_0000);
            #1;
            check("wr_wen",   ram_wen[0], wexp[k]);
            check("wr_en",    ram_en[0],  1'b1);
            check("wr_dok",   data_ok[0], (k > 0) ? 1'b1 : 1'b0);
            check("wr_wdata", ram_wdata[0], 32'hAB00_0000);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("wr_last_dok", data_ok[0], 1'b1);
        check("wr_rdata",    rdata[0],   32'h3C1A_0000);
        @(negedge clk); #1;
        check("wr_dok_end", data_ok[0], 1'b0);

        // LATENCY=3 back-to-back reads with req held
        @(negedge clk);
        drive(2, 1'b1, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("l3_acc0_ok", addr_ok[2], 1'b1);
        check("l3_acc0_en", ram_en[2],  1'b1);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, SIZE_WORD, 32'h4, 32'h0);
        #1;
        check("l3_w1_addr_ok", addr_ok[2], 1'b0);
        check("l3_w1_en",      ram_en[2],  1'b0);
        check("l3_w1_dok",     data_ok[2], 1'b0);
        check("l3_w1_rdata",   rdata[2],   32'h0000_FFFF);
        @(negedge clk); #1;
        check("l3_w2_addr_ok", addr_ok[2], 1'b0);
        check("l3_w2_dok",     data_ok[2], 1'b0);
        @(negedge clk); #1;
        check("l3_r1_dok",     data_ok[2],  1'b1);
        check("l3_r1_addr_ok", addr_ok[2],  1'b1);
        check("l3_acc1_en",    ram_en[2],   1'b1);
        check("l3_acc1_addr",  ram_addr[2], 32'h4);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("l3_w3_addr_ok", addr_ok[2], 1'b0);
        check("l3_w3_dok",     data_ok[2], 1'b0);
        check("l3_w3_rdata",   rdata[2],   32'h0004_FFFB);
        @(negedge clk); #1;
        check("l3_w4_dok", data_ok[2], 1'b0);
        @(negedge clk); #1;
        check("l3_r2_dok",   data_ok[2], 1'b1);
        check("l3_r2_rdata", rdata[2],   32'h0004_FFFB);
        @(negedge clk); #1;
        check("l3_idle_dok",     data_ok[2], 1'b0);
        check("l3_idle_addr_ok", addr_ok[2], 1'b1);

        // LATENCY=4, reset two cycles after accept abandons the read
        @(negedge clk);
        drive(3, 1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0);
        #1;
        check("l4_acc_en", ram_en[3], 1'b1);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("l4_w1_addr_ok", addr_ok[3], 1'b0);
        @(negedge clk);
        rst[3] = 1'b1;
        #1;
        check("l4_rst_addr_ok", addr_ok[3], 1'b0);
        check("l4_rst_dok",     data_ok[3], 1'b0);
        @(negedge clk);
        rst[3] = 1'b0;
        #1;
        check("l4_rel_addr_ok", addr_ok[3], 1'b1);
        check("l4_rel_rdata",   rdata[3],   32'h0);
        n_dok = 0;
        for (int c = 0; c < 8; c++) begin
            if (data_ok[3]) n_dok++;
            @(negedge clk); #1;
        end
        check("l4_no_dok", n_dok, 32'd0);

        // LATENCY=2 read followed by a write; rdata keeps the read value
        @(negedge clk);
        drive(1, 1'b1, 1'b0, SIZE_WORD, 32'h20, 32'h0);
        #1;
        check("l2_rd_en", ram_en[1], 1'b1);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SIZE_WORD, 32'h24, 32'hDEAD_BEEF);
        #1;
        check("l2_w1_addr_ok", addr_ok[1], 1'b0);
        check("l2_w1_wen",     ram_wen[1], 4'b0000);
        check("l2_w1_rdata",   rdata[1],   32'h0020_FFDF);
        @(negedge clk); #1;
        check("l2_rd_dok",  data_ok[1], 1'b1);
        check("l2_wr_wen",  ram_wen[1], 4'b1111);
        check("l2_rd_data", rdata[1],   32'h0020_FFDF);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check("l2_w2_dok",   data_ok[1], 1'b0);
        check("l2_w2_rdata", rdata[1],   32'h0020_FFDF);
        @(negedge clk); #1;
        check("l2_wr_dok",   data_ok[1], 1'b1);
        check("l2_wr_rdata", rdata[1],   32'h0020_FFDF);
        @(negedge clk); #1;
        check("l2_end_dok", data_ok[1], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
